// File: rtl/clz_seq_pkg.sv
// Shared types and sizing helpers for the sequential leading-zero controller.
package clz_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        CLZ_SEQ_IDLE = 2'd0,
        CLZ_SEQ_SCAN = 2'd1,
        CLZ_SEQ_DONE = 2'd2
    } clz_seq_state_e;

    function automatic int unsigned clz_seq_num_chunks(input int unsigned data_w,
                                                       input int unsigned chunk_w);
        return data_w / chunk_w;
    endfunction

    // Chunk index width; a single-chunk build still keeps a 1-bit index.
    function automatic int unsigned clz_seq_idx_w(input int unsigned num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/clz_seq_ctrl_clz.sv
// Narrow combinational leading-zero counter shared by the sequential controller.
// Output is meaningless for an all-zero input; callers detect that separately.
module clz #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic [OUT_W-1:0]  count_c
);

    // Scan LSB upward so the highest set bit wins the last assignment.
    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                count_c = OUT_W'(DATA_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/clz_seq_ctrl.sv
// Wide leading-zero count by time-sharing one narrow clz over chunks, MSB chunk first.
// Optional macro CLZ_SEQ_EARLY_EXIT_EN: stop scanning at the first nonzero chunk.
module clz_seq_ctrl
    import clz_seq_pkg::*;
#(
    parameter int unsigned  DATA_W  = 64,
    parameter int unsigned  CHUNK_W = 16,
    localparam int unsigned CNT_W   = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              zero_o
);

    localparam int unsigned NUM_CHUNKS = clz_seq_num_chunks(DATA_W, CHUNK_W);
    localparam int unsigned IDX_W      = clz_seq_idx_w(NUM_CHUNKS);
    localparam int unsigned CLZ_W      = $clog2(CHUNK_W);

    clz_seq_state_e    state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] operand, operand_nxt;
    logic              valid_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              zero_nxt;

    logic [CHUNK_W-1:0] chunk;
    logic [CLZ_W-1:0]   chunk_lz;
    logic               chunk_nz;
    logic               last_chunk;
    logic [CNT_W-1:0]   chunk_cnt;

`ifndef CLZ_SEQ_EARLY_EXIT_EN
    logic             found, found_nxt;
    logic [CNT_W-1:0] pend, pend_nxt;
`endif

    // Chunk index 0 is the most significant CHUNK_W bits of the operand.
    always_comb begin
        chunk = '0;
        for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
            if (idx == IDX_W'(c)) begin
                chunk = operand[DATA_W-1-c*CHUNK_W -: CHUNK_W];
            end
        end
    end

    clz #(
        .DATA_W (CHUNK_W),
        .OUT_W  (CLZ_W)
    ) u_clz (
        .data    (chunk),
        .count_c (chunk_lz)
    );

    assign chunk_nz   = |chunk;
    assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));
    assign chunk_cnt  = CNT_W'(idx) * CNT_W'(CHUNK_W) + CNT_W'(chunk_lz);
    assign ready_o    = (state == CLZ_SEQ_IDLE);

    // Next-state and result-register logic.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        operand_nxt = operand;
        valid_nxt   = valid_o;
        count_nxt   = count_o;
        zero_nxt    = zero_o;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
        found_nxt   = found;
        pend_nxt    = pend;
`endif

        case (state)
            CLZ_SEQ_IDLE: begin
                if (valid_i) begin
                    operand_nxt = data_i;
                    idx_nxt     = '0;
                    state_nxt   = CLZ_SEQ_SCAN;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
                    found_nxt   = 1'b0;
`endif
                end
            end

            CLZ_SEQ_SCAN: begin
`ifdef CLZ_SEQ_EARLY_EXIT_EN
                if (chunk_nz) begin
                    count_nxt = chunk_cnt;
                    zero_nxt  = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = CLZ_SEQ_DONE;
                end else if (last_chunk) begin
                    count_nxt = CNT_W'(DATA_W);
                    zero_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = CLZ_SEQ_DONE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
`else
                // Only the first nonzero chunk is kept; the scan length stays fixed.
                if (chunk_nz && !found) begin
                    found_nxt = 1'b1;
                    pend_nxt  = chunk_cnt;
                end
                if (last_chunk) begin
                    valid_nxt = 1'b1;
                    state_nxt = CLZ_SEQ_DONE;
                    if (found) begin
                        count_nxt = pend;
                        zero_nxt  = 1'b0;
                    end else if (chunk_nz) begin
                        count_nxt = chunk_cnt;
                        zero_nxt  = 1'b0;
                    end else begin
                        count_nxt = CNT_W'(DATA_W);
                        zero_nxt  = 1'b1;
                    end
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
`endif
            end

            CLZ_SEQ_DONE: begin
                if (ready_i) begin
                    valid_nxt = 1'b0;
                    state_nxt = CLZ_SEQ_IDLE;
                end
            end

            default: begin
                state_nxt = CLZ_SEQ_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLZ_SEQ_IDLE;
            idx     <= '0;
            operand <= '0;
            valid_o <= 1'b0;
            count_o <= '0;
            zero_o  <= 1'b0;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
            found   <= 1'b0;
            pend    <= '0;
`endif
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            operand <= operand_nxt;
            valid_o <= valid_nxt;
            count_o <= count_nxt;
            zero_o  <= zero_nxt;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
            found   <= found_nxt;
            pend    <= pend_nxt;
`endif
        end
    end

endmodule
